// File: rtl/ht_pkg.sv
// rtl/ht_pkg.sv - shared types, widths and hash for the hash-table command front-end
package ht_pkg;

    localparam int KEY_W  = 4;
    localparam int VAL_W  = 4;
    localparam int HASH_W = 3;

    typedef enum logic [1:0] {
        CMD_LOOKUP = 2'd0,
        CMD_INSERT = 2'd1,
        CMD_DELETE = 2'd2,
        CMD_RSVD   = 2'd3
    } ht_cmd_e;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,
        STATUS_FULL     = 2'd1,
        STATUS_NOTFOUND = 2'd2,
        STATUS_BUSY     = 2'd3
    } ht_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ht_state_e;

    typedef struct packed {
        logic [1:0]       cmd;
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } ht_req_t;

    function automatic logic [HASH_W-1:0] ht_hash(input logic [KEY_W-1:0] key);
        return key[2:0] ^ {2'b00, key[3]};
    endfunction

endpackage

// File: rtl/ht_cmd_frontend_if.sv
// rtl/ht_cmd_frontend_if.sv - request/response handshake bundle for the hash-table front-end
interface ht_cmd_frontend_if;
    import ht_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_cmd;
    logic [KEY_W-1:0] req_key;
    logic [VAL_W-1:0] req_val;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_status;
    logic [VAL_W-1:0] rsp_data;
    logic [1:0]       rsp_cmd;

    modport master (
        output req_valid, req_cmd, req_key, req_val, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_data, rsp_cmd
    );

    modport slave (
        input  req_valid, req_cmd, req_key, req_val, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_data, rsp_cmd
    );

endinterface

// File: rtl/ht_req_fifo.sv
// rtl/ht_req_fifo.sv - synchronous request FIFO (pointer + count), used when HT_REQ_FIFO_EN is defined
module ht_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A full FIFO refuses a push even when the same cycle pops.
    assign w_push  = i_push && (r_count != FULL_CNT);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ht_cmd_frontend.sv
// rtl/ht_cmd_frontend.sv - hash-table request front-end; optional request FIFO under HT_REQ_FIFO_EN
module ht_cmd_frontend
    import ht_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    ht_cmd_frontend_if.slave  bus,
    output logic              tbl_rst_n,
    output logic              tbl_go,
    output logic [HASH_W-1:0] tbl_hash,
    output logic [KEY_W-1:0]  tbl_key,
    output logic [VAL_W-1:0]  tbl_val,
    output logic [1:0]        tbl_cmd,
    input  logic [1:0]        tbl_status,
    input  logic [VAL_W-1:0]  tbl_out
);
    ht_state_e         r_state;
    ht_state_e         w_next;
    ht_req_t           w_req;
    logic              w_req_avail;
    logic              w_latch;
    logic              w_capture;
    logic [1:0]        r_cmd;
    logic [KEY_W-1:0]  r_key;
    logic [VAL_W-1:0]  r_val;
    logic [HASH_W-1:0] r_hash;
    logic [1:0]        r_rsp_status;
    logic [VAL_W-1:0]  r_rsp_data;
    logic [1:0]        r_rsp_cmd;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two of at least 2");
    end

`ifdef HT_REQ_FIFO_EN
    logic    w_fifo_full;
    logic    w_fifo_empty;
    ht_req_t w_push_data;

    assign w_push_data = '{cmd: bus.req_cmd, key: bus.req_key, val: bus.req_val};

    ht_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(ht_req_t))
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.req_valid),
        .i_wdata (w_push_data),
        .i_pop   (w_latch),
        .o_rdata (w_req),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_req_avail   = !w_fifo_empty;
    assign bus.req_ready = !w_fifo_full;
`else
    assign w_req         = '{cmd: bus.req_cmd, key: bus.req_key, val: bus.req_val};
    assign w_req_avail   = bus.req_valid;
    assign bus.req_ready = (r_state == ST_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_avail) begin
                    w_latch = 1'b1;
                    w_next  = (w_req.cmd == CMD_RSVD) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tbl_status == STATUS_BUSY) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tbl_status != STATUS_BUSY) begin
                    w_capture = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Table inputs only load in IDLE so they stay frozen across every probe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd        <= '0;
            r_key        <= '0;
            r_val        <= '0;
            r_hash       <= '0;
            r_rsp_status <= '0;
            r_rsp_data   <= '0;
            r_rsp_cmd    <= '0;
        end else begin
            if (w_latch) begin
                r_cmd  <= w_req.cmd;
                r_key  <= w_req.key;
                r_val  <= w_req.val;
                r_hash <= ht_hash(w_req.key);
                if (w_req.cmd == CMD_RSVD) begin
                    r_rsp_status <= STATUS_NOTFOUND;
                    r_rsp_data   <= '0;
                    r_rsp_cmd    <= w_req.cmd;
                end
            end
            if (w_capture) begin
                r_rsp_status <= tbl_status;
                r_rsp_data   <= tbl_out;
                r_rsp_cmd    <= r_cmd;
            end
        end
    end

    // go falls combinationally the cycle the table first reports BUSY.
    assign tbl_go         = (r_state == ST_ISSUE) && (tbl_status != STATUS_BUSY);
    assign tbl_rst_n      = ~rst;
    assign tbl_hash       = r_hash;
    assign tbl_key        = r_key;
    assign tbl_val        = r_val;
    assign tbl_cmd        = r_cmd;
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_cmd    = r_rsp_cmd;

endmodule

// File: tb/tb_ht_cmd_frontend.sv
// tb/tb_ht_cmd_frontend.sv - self-checking bench for ht_cmd_frontend with a behavioural probing table
module tb_ht_cmd_frontend;
    import ht_pkg::*;

`ifdef HT_REQ_FIFO_EN
    localparam int LAT_ADJ = 1;
`else
    localparam int LAT_ADJ = 0;
`endif
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ht_cmd_frontend_if bus();
    logic       tbl_rst_n, tbl_go;
    logic [2:0] tbl_hash;
    logic [3:0] tbl_key, tbl_val, tbl_out;
    logic [1:0] tbl_cmd, tbl_status;

    ht_cmd_frontend #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .tbl_rst_n(tbl_rst_n), .tbl_go(tbl_go), .tbl_hash(tbl_hash), .tbl_key(tbl_key),
        .tbl_val(tbl_val), .tbl_cmd(tbl_cmd), .tbl_status(tbl_status), .tbl_out(tbl_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Probing table: linear probe from the hash over all 8 slots; a miss or full costs 9 busy cycles.
    logic [7:0] s_used;
    logic [3:0] s_key [8];
    logic [3:0] s_val [8];
    int         t_rem = 0;
    int         last_probes = 0;
    logic [1:0] fin_st;
    logic       fin_hit;
    logic [3:0] fin_out;
    int         w_p;
    logic [2:0] w_slot;

    function automatic int find_slot(input logic [2:0] h, input logic [3:0] k, input bit want_empty);
        for (int i = 0; i < 8; i++) begin
            if (want_empty ? !s_used[h + 3'(i)] : (s_used[h + 3'(i)] && s_key[h + 3'(i)] == k))
                return i;
        end
        return 8;
    endfunction

    always_comb w_p = find_slot(tbl_hash, tbl_key, tbl_cmd == CMD_INSERT);
    assign w_slot = tbl_hash + w_p[2:0];

    always @(posedge clk) begin
        if (!tbl_rst_n) begin
            s_used     <= '0;
            t_rem      <= 0;
            tbl_status <= STATUS_OK;
            tbl_out    <= '0;
        end else if (t_rem != 0) begin
            t_rem <= t_rem - 1;
            if (t_rem == 1) begin
                tbl_status <= fin_st;
                if (fin_hit) tbl_out <= fin_out;
            end
        end else if (tbl_go) begin
            t_rem       <= (w_p == 8) ? 9 : w_p + 1;
            last_probes <= (w_p == 8) ? 9 : w_p + 1;
            tbl_status  <= STATUS_BUSY;
            fin_hit     <= (tbl_cmd != CMD_INSERT) && (w_p < 8);
            fin_out     <= s_val[w_slot];
            if (tbl_cmd == CMD_INSERT) fin_st <= (w_p < 8) ? STATUS_OK : STATUS_FULL;
            else                       fin_st <= (w_p < 8) ? STATUS_OK : STATUS_NOTFOUND;
            if (w_p < 8 && tbl_cmd == CMD_INSERT) begin
                s_used[w_slot] <= 1'b1;
                s_key[w_slot]  <= tbl_key;
                s_val[w_slot]  <= tbl_val;
            end
            if (w_p < 8 && tbl_cmd == CMD_DELETE) s_used[w_slot] <= 1'b0;
        end
    end

    int         go_cnt = 0;
    logic [2:0] go_hash = '0;
    always @(negedge clk) begin
        if (tbl_go === 1'b1) begin
            go_cnt  <= go_cnt + 1;
            go_hash <= tbl_hash;
        end
    end

    // Reference: key -> value map with an occupancy count, plus the last data the table emitted.
    bit         ref_used [16];
    logic [3:0] ref_val  [16];
    int         ref_cnt;
    logic [3:0] ref_last;

    task automatic ref_clear();
        for (int i = 0; i < 16; i++) ref_used[i] = 1'b0;
        ref_cnt  = 0;
        ref_last = '0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, bus.req_ready, 1);
        check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
        check({pfx, "_rsp_status"}, bus.rsp_status, 0);
        check({pfx, "_rsp_data"}, bus.rsp_data, 0);
        check({pfx, "_rsp_cmd"}, bus.rsp_cmd, 0);
        check({pfx, "_tbl_go"}, tbl_go, 0);
        check({pfx, "_tbl_hash"}, tbl_hash, 0);
        check({pfx, "_tbl_key"}, tbl_key, 0);
        check({pfx, "_tbl_val"}, tbl_val, 0);
        check({pfx, "_tbl_cmd"}, tbl_cmd, 0);
    endtask

    task automatic run_op(input logic [1:0] cmd, input logic [3:0] key, input logic [3:0] val,
                          input int hold, output int lat, output logic [1:0] st);
        logic [1:0] exp_st;
        logic [3:0] exp_data;
        int         exp_lat, go0, n;
        exp_st   = STATUS_NOTFOUND;
        exp_data = ref_last;
        case (cmd)
            CMD_LOOKUP: if (ref_used[key]) begin
                exp_st = STATUS_OK; exp_data = ref_val[key]; ref_last = ref_val[key];
            end
            CMD_INSERT: if (ref_cnt < 8) begin
                exp_st = STATUS_OK; ref_used[key] = 1'b1; ref_val[key] = val; ref_cnt++;
            end else exp_st = STATUS_FULL;
            CMD_DELETE: if (ref_used[key]) begin
                exp_st = STATUS_OK; exp_data = ref_val[key]; ref_last = ref_val[key];
                ref_used[key] = 1'b0; ref_cnt--;
            end
            default: exp_data = '0;
        endcase

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_key = key; bus.req_val = val;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("req_accept", n < 50, 1);
        @(posedge clk);
        go0 = go_cnt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        exp_lat = ((cmd == CMD_RSVD) ? 1 : 3 + last_probes) + LAT_ADJ;
        st = bus.rsp_status;
        check("rsp_status", st, exp_st);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_cmd", bus.rsp_cmd, cmd);
        check("latency", lat, exp_lat);
        check("go_cycles", go_cnt - go0, (cmd == CMD_RSVD) ? 0 : 1);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_status", bus.rsp_status, exp_st);
            check("stall_data", bus.rsp_data, exp_data);
            check("stall_cmd", bus.rsp_cmd, cmd);
`ifndef HT_REQ_FIFO_EN
            check("stall_req_ready", bus.req_ready, 0);
`endif
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    int         lat, acc, drained, n;
    logic [1:0] st, rcmd;
    logic [3:0] rkey;

    initial begin
        bus.req_valid = 1'b0; bus.req_cmd = '0; bus.req_key = '0; bus.req_val = '0;
        bus.rsp_ready = 1'b0;
        ref_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        run_op(CMD_INSERT, 4'd5, 4'd9, 0, lat, st);
        check("ins5_lat", lat, 4 + LAT_ADJ);
        check("ins5_status", st, STATUS_OK);
        check("ins5_hash", go_hash, 5);
        run_op(CMD_LOOKUP, 4'd5, 4'd0, 0, lat, st);
        run_op(CMD_DELETE, 4'd5, 4'd0, 0, lat, st);
        run_op(CMD_LOOKUP, 4'd5, 4'd0, 0, lat, st);
        check("miss_lat", lat, 12 + LAT_ADJ);
        check("miss_status", st, STATUS_NOTFOUND);

        run_op(CMD_INSERT, 4'd5, 4'd2, 0, lat, st);
        run_op(CMD_INSERT, 4'd12, 4'd7, 0, lat, st);
        check("key12_hash", go_hash, 5);
        run_op(CMD_LOOKUP, 4'd12, 4'd0, 0, lat, st);
        check("chain_lat", lat, 5 + LAT_ADJ);
        check("chain_status", st, STATUS_OK);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        ref_clear();
        for (int k = 0; k < 8; k++) run_op(CMD_INSERT, 4'(k), 4'(k + 1), 0, lat, st);
        run_op(CMD_INSERT, 4'd8, 4'd1, 0, lat, st);
        check("full_status", st, STATUS_FULL);
        check("full_lat", lat, 12 + LAT_ADJ);
        run_op(CMD_RSVD, 4'd3, 4'd3, 0, lat, st);
        check("rsvd_lat", lat, 1 + LAT_ADJ);

        run_op(CMD_LOOKUP, 4'd3, 4'd0, 10, lat, st);

`ifdef HT_REQ_FIFO_EN
        acc = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_cmd = CMD_RSVD;
        repeat (12) begin
            if (bus.req_ready === 1'b1) acc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("fifo_accepts", acc, DEPTH + 1);
        check("fifo_full_ready", bus.req_ready, 0);
        drained = 0;
        bus.rsp_ready = 1'b1;
        repeat (30) begin
            if (bus.rsp_valid === 1'b1) begin
                drained++;
                check("fifo_rsp_status", bus.rsp_status, STATUS_NOTFOUND);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        check("fifo_drained", drained, DEPTH + 1);
`endif

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_cmd = CMD_LOOKUP; bus.req_key = 4'd9; bus.req_val = '0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("wait_accept", n < 50, 1);
        @(posedge clk);
        @(negedge clk); bus.req_valid = 1'b0;
        repeat (2 + LAT_ADJ) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        ref_clear();
        run_op(CMD_LOOKUP, 4'd3, 4'd0, 0, lat, st);
        check("post_rst_status", st, STATUS_NOTFOUND);
        check("post_rst_lat", lat, 12 + LAT_ADJ);

        repeat (60) begin
            rcmd = 2'($urandom_range(0, 3));
            rkey = 4'($urandom_range(0, 15));
            if (rcmd == CMD_INSERT && ref_used[rkey]) rcmd = CMD_LOOKUP;
            run_op(rcmd, rkey, 4'($urandom), 0, lat, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
